axis_selector_matrix: RTL and testbench
=======================================

// Module: axis_selector_matrix
// PURPOSE
//  Parametrised NUM_IN x NUM_OUT AXI-stream crossbar for the RPSPMC signal path.
//  Any output can take any input, configured over the shared config_addr/config_data bus.
//  Each output has its own mode: pass, sample-and-hold, decimate or test constant.
//  Sits between the ADC/filter/monitor stream sources and the controller/recorder sinks.
// PARAMETERS
//  NUM_IN                 16    number of slave streams, 2..16
//  NUM_OUT                8     number of master streams, 1..16
//  SAXIS_TDATA_WIDTH      32    input sample width
//  MAXIS_TDATA_WIDTH      32    output sample width
//  configuration_address  2000  config_addr value that loads this block
// PORTS
//  a_clk          in   1                        single clock; all logic on rising edge
//  a_rst          in   1                        reset, synchronous, active-high
//  config_addr    in   32                       config bus address
//  config_data    in   512                      config bus data
//  S_AXIS_tdata   in   NUM_IN*SAXIS_TDATA_WIDTH   input i occupies slice [i*W +: W]
//  S_AXIS_tvalid  in   NUM_IN                   per-input valid; no tready, sources never stall
//  M_AXIS_tdata   out  NUM_OUT*MAXIS_TDATA_WIDTH  output k occupies slice [k*W +: W]
//  M_AXIS_tvalid  out  NUM_OUT                  per-output valid
//  cfg_count      out  16                       number of config loads accepted, wraps at 16'hFFFF
// BEHAVIOUR
//  Config load: in any cycle where config_addr==configuration_address, all fields below load on that edge.
//   Bits [4k+3:4k], k<NUM_OUT, bits 0..63: source select for output k.
//   Bits [64+2k+1:64+2k], bits 64..95: mode for output k.
//     0=PASS, 1=HOLD, 2=DECIM, 3=TEST.
//   Bits [127:96]: test value. Bits [143:128]: decimation factor D; D=0 is treated as 1.
//   A held address reloads every cycle. Each load clears all decimation counters and hold-seen flags.
//   Each load increments cfg_count.
//  Reset (a_rst=1 on a rising edge):
//   Select k = k mod NUM_IN; all modes PASS; test value 0; D=1.
//   All M_AXIS_tdata=0, all M_AXIS_tvalid=0, cfg_count=0; input and output stage registers cleared.
//   a_rst has priority over a config load in the same cycle.
//  Pipeline: stage 1 registers all inputs; stage 2 registers all outputs.
//   Latency is 2 a_clk cycles from input to output for PASS, HOLD and DECIM.
//   A new select or mode affects outputs from the 2nd edge after the load edge.
//   There are no combinational paths from inputs to outputs.
//  Width rule: if MAXIS > SAXIS, data is sign-extended. If MAXIS < SAXIS, the LSBs are kept.
//  Out-of-range select (>= NUM_IN): output tdata=0 and tvalid=0 in every mode except TEST.
//  PASS: output tvalid and tdata follow the selected input, registered.
//  HOLD: on each valid beat of the source, tdata captures the sample.
//   tvalid=1 every cycle once the first beat has been seen since reset or load, 0 before that.
//  DECIM: a per-output 16-bit counter counts valid source beats.
//   On the beat where count==D-1: output tvalid=1 with that beat's data, and the counter returns to 0.
//   In all other cycles tvalid=0 and tdata holds its last value.
//  TEST: tdata = test value, resized by the width rule; tvalid=1 every cycle; the select is ignored.
//  Several outputs may select the same input; each output keeps its own independent state.
// TESTING
//  1. Reset. Drive input i with data 100+i and valid=1. Expect output k = 100+k with tvalid=1, 2 cycles after release.
//  2. Load select k=15-k, PASS. Expect outputs to change exactly 2 edges after the load edge, with no mixed-source cycle.
//  3. Output 0: DECIM, D=4, source valid every cycle with data 0,1,2,...
//     Expect tvalid high on samples 3,7,11 only. Repeat with D=0 and expect pass-through.
//  4. Output 1: HOLD. Source valid only at t=10 with data 0xDEAD.
//     Expect tvalid=0 until the sample, then tdata=0xDEAD and tvalid=1 held for 100 cycles.
//  5. Output 2: TEST with value 0x80000000, MAXIS=40.
//     Expect tdata=40'hFF80000000 and tvalid=1. Select 15 with NUM_IN=12 in PASS: expect 0/0.
//  6. Assert a_rst together with a config write while DECIM is mid-count.
//     Expect defaults, counters at 0, and cfg_count=0.

Source files
------------

// File: rtl/axis_selector_matrix.sv
// -----------------------------------------------------------------------------
// axis_selector_matrix
//   NUM_IN x NUM_OUT AXI-stream crossbar. Each output picks any input through a
//   4-bit select and applies its own mode: PASS, HOLD (sample-and-hold),
//   DECIM (keep one valid beat in D) or TEST (constant test value).
//   Configuration arrives over the shared config_addr/config_data bus.
//
// Ports
//   a_clk          single clock, rising edge
//   a_rst          synchronous active-high reset
//   config_addr    config bus address; equal to configuration_address loads
//   config_data    config bus data: [63:0] selects, [95:64] modes,
//                  [127:96] test value, [143:128] decimation factor
//   S_AXIS_tdata   input i at [i*SAXIS_TDATA_WIDTH +: SAXIS_TDATA_WIDTH]
//   S_AXIS_tvalid  per-input valid (no backpressure)
//   M_AXIS_tdata   output k at [k*MAXIS_TDATA_WIDTH +: MAXIS_TDATA_WIDTH]
//   M_AXIS_tvalid  per-output valid
//   cfg_count      number of accepted config loads (wraps)
// -----------------------------------------------------------------------------
module axis_selector_matrix #(
  parameter int          NUM_IN                = 16,
  parameter int          NUM_OUT               = 8,
  parameter int          SAXIS_TDATA_WIDTH     = 32,
  parameter int          MAXIS_TDATA_WIDTH     = 32,
  parameter logic [31:0] configuration_address = 32'd2000
) (
  input  logic                                 a_clk,
  input  logic                                 a_rst,
  input  logic [31:0]                          config_addr,
  input  logic [511:0]                         config_data,
  input  logic [NUM_IN*SAXIS_TDATA_WIDTH-1:0]  S_AXIS_tdata,
  input  logic [NUM_IN-1:0]                    S_AXIS_tvalid,
  output logic [NUM_OUT*MAXIS_TDATA_WIDTH-1:0] M_AXIS_tdata,
  output logic [NUM_OUT-1:0]                   M_AXIS_tvalid,
  output logic [15:0]                          cfg_count
);

  localparam int SW = SAXIS_TDATA_WIDTH;
  localparam int MW = MAXIS_TDATA_WIDTH;
  localparam logic [4:0] NUM_IN_L = 5'(NUM_IN);

  typedef enum logic [1:0] {
    MODE_PASS  = 2'd0,
    MODE_HOLD  = 2'd1,
    MODE_DECIM = 2'd2,
    MODE_TEST  = 2'd3
  } mode_t;

  // Width rule: sign-extend when widening, keep LSBs when narrowing.
  function automatic logic [MW-1:0] fit_s(input logic [SW-1:0] x);
    logic signed [SW-1:0] xs;
    xs = x;
    return MW'(xs);
  endfunction

  function automatic logic [MW-1:0] fit_t(input logic [31:0] x);
    logic signed [31:0] xs;
    xs = x;
    return MW'(xs);
  endfunction

  logic [NUM_IN*SW-1:0]          s_data_p0;
  logic [NUM_IN-1:0]             s_vld_p0;
  logic                          ld_p0;
  logic [143:0]                  cfg_p0;

  logic [NUM_OUT-1:0][3:0]       act_sel;
  logic [NUM_OUT-1:0][1:0]       act_mode;
  logic [31:0]                   act_test;
  logic [15:0]                   act_dec;

  logic [15:0][SW-1:0]           src_data;
  logic [15:0]                   src_vld;
  logic [NUM_OUT-1:0][MW-1:0]    pick_data;
  logic [NUM_OUT-1:0]            pick_vld;
  logic [NUM_OUT-1:0]            pick_ok;
  logic [15:0]                   dec_last;
  logic [MW-1:0]                 test_fit;

  logic [NUM_OUT-1:0][MW-1:0]    out_data_p1;
  logic [NUM_OUT-1:0]            vld_p1;
  logic [NUM_OUT-1:0][15:0]      dcnt_p1;
  logic [NUM_OUT-1:0]            seen_p1;

  logic                          cfg_hit;
  logic                          unused_bits;

  assign cfg_hit     = (config_addr == configuration_address);
  assign unused_bits = ^{config_data[511:144], cfg_p0};

  // Inputs beyond NUM_IN are padded with zero so the 4-bit select indexes safely;
  // pick_ok still forces out-of-range selects to 0/0 in every mode but TEST.
  always_comb begin
    src_data  = '0;
    src_vld   = '0;
    pick_data = '0;
    pick_vld  = '0;
    pick_ok   = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      src_data[i] = s_data_p0[i*SW +: SW];
      src_vld[i]  = s_vld_p0[i];
    end
    for (int k = 0; k < NUM_OUT; k++) begin
      pick_ok[k]   = ({1'b0, act_sel[k]} < NUM_IN_L);
      pick_vld[k]  = pick_ok[k] & src_vld[act_sel[k]];
      pick_data[k] = pick_ok[k] ? fit_s(src_data[act_sel[k]]) : '0;
    end
  end

  // D = 0 behaves as D = 1, so the terminal count is 0 in both cases.
  assign dec_last = (act_dec == 16'd0) ? 16'd0 : act_dec - 16'd1;
  assign test_fit = fit_t(act_test);

  always_ff @(posedge a_clk) begin
    if (a_rst) begin
      s_data_p0   <= '0;
      s_vld_p0    <= '0;
      ld_p0       <= 1'b0;
      cfg_p0      <= '0;
      cfg_count   <= '0;
      act_test    <= '0;
      act_dec     <= 16'd1;
      for (int k = 0; k < NUM_OUT; k++) begin
        act_sel[k]  <= 4'(k % NUM_IN);
        act_mode[k] <= MODE_PASS;
      end
      out_data_p1 <= '0;
      vld_p1      <= '0;
      dcnt_p1     <= '0;
      seen_p1     <= '0;
    end else begin
      // ---- stage 1: register inputs and the config write ----
      s_data_p0 <= S_AXIS_tdata;
      s_vld_p0  <= S_AXIS_tvalid;
      ld_p0     <= cfg_hit;
      cfg_p0    <= config_data[143:0];
      if (cfg_hit) begin
        cfg_count <= cfg_count + 16'd1;
      end

      // The registered write becomes active one edge later, so the outputs
      // switch on the 2nd edge after the load, in step with the data path.
      if (ld_p0) begin
        for (int k = 0; k < NUM_OUT; k++) begin
          act_sel[k]  <= cfg_p0[4*k +: 4];
          act_mode[k] <= cfg_p0[64 + 2*k +: 2];
        end
        act_test <= cfg_p0[127:96];
        act_dec  <= cfg_p0[143:128];
      end

      // ---- stage 2: per-output mode logic and output registers ----
      for (int k = 0; k < NUM_OUT; k++) begin
        case (mode_t'(act_mode[k]))
          MODE_PASS: begin
            out_data_p1[k] <= pick_data[k];
            vld_p1[k]      <= pick_vld[k];
          end
          MODE_HOLD: begin
            if (!pick_ok[k]) begin
              out_data_p1[k] <= '0;
              vld_p1[k]      <= 1'b0;
            end else begin
              if (pick_vld[k]) begin
                out_data_p1[k] <= pick_data[k];
                seen_p1[k]     <= 1'b1;
              end
              vld_p1[k] <= seen_p1[k] | pick_vld[k];
            end
          end
          MODE_DECIM: begin
            if (!pick_ok[k]) begin
              out_data_p1[k] <= '0;
              vld_p1[k]      <= 1'b0;
            end else begin
              vld_p1[k] <= 1'b0;
              if (pick_vld[k]) begin
                if (dcnt_p1[k] == dec_last) begin
                  vld_p1[k]      <= 1'b1;
                  out_data_p1[k] <= pick_data[k];
                  dcnt_p1[k]     <= 16'd0;
                end else begin
                  dcnt_p1[k] <= dcnt_p1[k] + 16'd1;
                end
              end
            end
          end
          default: begin
            out_data_p1[k] <= test_fit;
            vld_p1[k]      <= 1'b1;
          end
        endcase
      end

      // A load restarts every output's decimation count and hold history.
      if (ld_p0) begin
        dcnt_p1 <= '0;
        seen_p1 <= '0;
      end
    end
  end

  assign M_AXIS_tdata  = out_data_p1;
  assign M_AXIS_tvalid = vld_p1;

endmodule

// File: tb/tb_axis_selector_matrix.sv
module tb_axis_selector_matrix;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  cfg_addr;
  logic [511:0] cfg_data;
  logic [511:0] s_tdata;
  logic [15:0]  s_tvalid;
  logic [255:0] m_tdata;
  logic [7:0]   m_tvalid;
  logic [15:0]  cnt;

  logic [31:0]  cfg2_addr;
  logic [511:0] cfg2_data;
  logic [383:0] s2_tdata;
  logic [11:0]  s2_tvalid;
  logic [159:0] m2_tdata;
  logic [3:0]   m2_tvalid;
  logic [15:0]  cnt2;

  int n_chk  = 0;
  int n_pass = 0;
  int exp_cnt;

  typedef struct {
    logic [63:0] sel;
    logic [31:0] mode;
    logic [31:0] tv;
    logic [15:0] d;
    logic [31:0] base;
    logic [15:0] vld;
    int          k;
    logic [31:0] exp_d;
    logic        exp_v;
  } vec_t;

  vec_t tbl[11];

  always #5 clk = ~clk;

  axis_selector_matrix #(
    .NUM_IN(16), .NUM_OUT(8), .SAXIS_TDATA_WIDTH(32), .MAXIS_TDATA_WIDTH(32),
    .configuration_address(32'd2000)
  ) u_dut (
    .a_clk(clk), .a_rst(rst), .config_addr(cfg_addr), .config_data(cfg_data),
    .S_AXIS_tdata(s_tdata), .S_AXIS_tvalid(s_tvalid),
    .M_AXIS_tdata(m_tdata), .M_AXIS_tvalid(m_tvalid), .cfg_count(cnt)
  );

  axis_selector_matrix #(
    .NUM_IN(12), .NUM_OUT(4), .SAXIS_TDATA_WIDTH(32), .MAXIS_TDATA_WIDTH(40),
    .configuration_address(32'd2000)
  ) u_dut2 (
    .a_clk(clk), .a_rst(rst), .config_addr(cfg2_addr), .config_data(cfg2_data),
    .S_AXIS_tdata(s2_tdata), .S_AXIS_tvalid(s2_tvalid),
    .M_AXIS_tdata(m2_tdata), .M_AXIS_tvalid(m2_tvalid), .cfg_count(cnt2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [511:0] mk_cfg(input logic [63:0] sel, input logic [31:0] mode,
                                          input logic [31:0] tv, input logic [15:0] d);
    logic [511:0] r;
    r = '0;
    r[63:0]    = sel;
    r[95:64]   = mode;
    r[127:96]  = tv;
    r[143:128] = d;
    return r;
  endfunction

  task automatic set_inputs(input logic [31:0] base, input logic [15:0] vld);
    for (int i = 0; i < 16; i++) s_tdata[i*32 +: 32] = base + 32'(i);
    s_tvalid = vld;
  endtask

  task automatic load_cfg(input logic [511:0] c);
    cfg_addr = 32'd2000;
    cfg_data = c;
    tick();
    cfg_addr = 32'd0;
  endtask

  logic [255:0] exp_vec;
  logic [31:0]  last;
  logic         ev;
  int           m;

  initial begin
    tbl[0]  = '{64'h76543210, 32'h0,    32'h0,        16'd1, 32'd100,    16'hFFFF, 3, 32'd103,      1'b1};
    tbl[1]  = '{64'h89ABCDEF, 32'h0,    32'h0,        16'd1, 32'd100,    16'hFFFF, 0, 32'd115,      1'b1};
    tbl[2]  = '{64'h89ABCDEF, 32'h0,    32'h0,        16'd1, 32'd100,    16'hFFFF, 7, 32'd108,      1'b1};
    tbl[3]  = '{64'h55555555, 32'h0,    32'h0,        16'd1, 32'd200,    16'h0020, 4, 32'd205,      1'b1};
    tbl[4]  = '{64'h55555555, 32'h0,    32'h0,        16'd1, 32'd200,    16'hFFDF, 4, 32'd205,      1'b0};
    tbl[5]  = '{64'h76543210, 32'h3000, 32'h12345678, 16'd1, 32'd100,    16'h0000, 6, 32'h12345678, 1'b1};
    tbl[6]  = '{64'h76543210, 32'h30,   32'h80000000, 16'd1, 32'd100,    16'h0000, 2, 32'h80000000, 1'b1};
    tbl[7]  = '{64'h76543210, 32'h40,   32'h0,        16'd1, 32'd300,    16'hFFFF, 3, 32'd303,      1'b1};
    tbl[8]  = '{64'h76543210, 32'h8,    32'h0,        16'd1, 32'd300,    16'hFFFF, 1, 32'd301,      1'b1};
    tbl[9]  = '{64'hFFFFFFFF, 32'hC00,  32'hCAFEF00D, 16'd1, 32'd0,      16'h0000, 5, 32'hCAFEF00D, 1'b1};
    tbl[10] = '{64'h76543910, 32'h0,    32'h0,        16'd1, 32'h1000,   16'hFFFF, 2, 32'h1009,     1'b1};

    rst = 1'b1;
    cfg_addr = '0; cfg_data = '0;
    cfg2_addr = '0; cfg2_data = '0;
    s2_tdata = '0; s2_tvalid = '0;
    set_inputs(32'd100, 16'hFFFF);
    repeat (3) tick();
    rst = 1'b0;

    // Reset state and 2-cycle latency after release
    chk("rst_tdata", {192'd0, m_tdata[63:0]} == 256'd0 && m_tdata == 256'd0, 1);
    chk("rst_tvalid", m_tvalid, 0);
    chk("rst_count", cnt, 0);
    tick();
    chk("lat1_tvalid", m_tvalid, 0);
    chk("lat1_tdata_zero", m_tdata == 256'd0, 1);
    tick();
    for (int k = 0; k < 8; k++) exp_vec[k*32 +: 32] = 32'd100 + 32'(k);
    chk("lat2_tvalid", m_tvalid, 8'hFF);
    chk("lat2_tdata", m_tdata == exp_vec, 1);
    exp_cnt = 0;

    // Select change takes effect exactly 2 edges after the load edge
    load_cfg(mk_cfg(64'h89ABCDEF, 32'h0, 32'h0, 16'd1));
    exp_cnt++;
    chk("sel_count", cnt, 64'(exp_cnt));
    chk("sel_e0_old", m_tdata == exp_vec, 1);
    tick();
    chk("sel_e1_old", m_tdata == exp_vec, 1);
    tick();
    for (int k = 0; k < 8; k++) exp_vec[k*32 +: 32] = 32'd115 - 32'(k);
    chk("sel_e2_new", m_tdata == exp_vec, 1);
    chk("sel_e2_vld", m_tvalid, 8'hFF);

    // Table-driven steady-state vectors
    for (int i = 0; i < 11; i++) begin
      set_inputs(tbl[i].base, tbl[i].vld);
      load_cfg(mk_cfg(tbl[i].sel, tbl[i].mode, tbl[i].tv, tbl[i].d));
      exp_cnt++;
      repeat (3) tick();
      chk($sformatf("vec%0d_data", i), m_tdata[tbl[i].k*32 +: 32], tbl[i].exp_d);
      chk($sformatf("vec%0d_vld", i), m_tvalid[tbl[i].k], tbl[i].exp_v);
    end
    chk("tbl_count", cnt, 64'(exp_cnt));

    // Held address reloads every cycle
    cfg_addr = 32'd2000;
    cfg_data = mk_cfg(64'h76543210, 32'h0, 32'h0, 16'd1);
    repeat (5) tick();
    cfg_addr = 32'd0;
    exp_cnt += 5;
    chk("held_count", cnt, 64'(exp_cnt));

    // DECIM D=4 on output 0
    set_inputs(32'd0, 16'h0000);
    load_cfg(mk_cfg(64'h76543210, 32'h2, 32'h0, 16'd4));
    exp_cnt++;
    repeat (3) tick();
    last = 0;
    for (int n = 0; n <= 16; n++) begin
      if (n < 16) begin s_tdata[31:0] = 32'(n); s_tvalid[0] = 1'b1; end
      else s_tvalid[0] = 1'b0;
      tick();
      if (n >= 1) begin
        m = n - 1;
        ev = (m % 4 == 3);
        chk($sformatf("decim4_vld_s%0d", m), m_tvalid[0], ev);
        if (ev) last = 32'(m);
        if (m >= 3) chk($sformatf("decim4_data_s%0d", m), m_tdata[31:0], last);
      end
    end

    // DECIM D=0 behaves as pass-through
    load_cfg(mk_cfg(64'h76543210, 32'h2, 32'h0, 16'd0));
    exp_cnt++;
    repeat (3) tick();
    for (int n = 0; n <= 8; n++) begin
      if (n < 8) begin s_tdata[31:0] = 32'(n + 50); s_tvalid[0] = 1'b1; end
      else s_tvalid[0] = 1'b0;
      tick();
      if (n >= 1) begin
        chk($sformatf("decim0_vld_s%0d", n - 1), m_tvalid[0], 1);
        chk($sformatf("decim0_data_s%0d", n - 1), m_tdata[31:0], 32'(n - 1 + 50));
      end
    end

    // HOLD on output 1: single beat at t=10
    s_tvalid[1] = 1'b0;
    load_cfg(mk_cfg(64'h76543210, 32'h4, 32'h0, 16'd1));
    exp_cnt++;
    repeat (3) tick();
    for (int t = 0; t < 112; t++) begin
      s_tdata[63:32] = (t == 10) ? 32'hDEAD : 32'h5000 + 32'(t);
      s_tvalid[1]    = (t == 10);
      tick();
      if (t >= 1) begin
        if (t - 1 < 10) chk($sformatf("hold_pre_vld_t%0d", t - 1), m_tvalid[1], 0);
        else begin
          chk($sformatf("hold_vld_t%0d", t - 1), m_tvalid[1], 1);
          chk($sformatf("hold_data_t%0d", t - 1), m_tdata[63:32], 32'hDEAD);
        end
      end
    end
    chk("hold_count", cnt, 64'(exp_cnt));

    // Reset with a simultaneous config write while DECIM is mid-count
    set_inputs(32'd0, 16'h0000);
    load_cfg(mk_cfg(64'h76543210, 32'h2, 32'h0, 16'd4));
    repeat (3) tick();
    s_tvalid[0] = 1'b1;
    repeat (2) tick();
    set_inputs(32'd100, 16'hFFFF);
    rst = 1'b1;
    cfg_addr = 32'd2000;
    cfg_data = mk_cfg(64'h76543210, 32'hFFFFFFFF, 32'hAAAA5555, 16'd7);
    tick();
    rst = 1'b0;
    cfg_addr = 32'd0;
    chk("rstcfg_count", cnt, 0);
    chk("rstcfg_count2", cnt2, 0);
    chk("rstcfg_tvalid", m_tvalid, 0);
    chk("rstcfg_tdata_zero", m_tdata == 256'd0, 1);
    chk("rstcfg_tvalid2", m2_tvalid, 0);
    repeat (2) tick();
    for (int k = 0; k < 8; k++) exp_vec[k*32 +: 32] = 32'd100 + 32'(k);
    chk("rstcfg_default_data", m_tdata == exp_vec, 1);
    chk("rstcfg_default_vld", m_tvalid, 8'hFF);
    tick();
    chk("rstcfg_no_late_load", m_tdata == exp_vec, 1);
    chk("rstcfg_count_after", cnt, 0);

    // Second instance: NUM_IN=12, MAXIS=40
    for (int i = 0; i < 12; i++) s2_tdata[i*32 +: 32] = 32'h10 + 32'(i);
    s2_tdata[3*32 +: 32]  = 32'h80000001;
    s2_tdata[11*32 +: 32] = 32'h7FFFFFFF;
    s2_tvalid = 12'hFFF;
    cfg2_addr = 32'd2000;
    cfg2_data = mk_cfg(64'hB03F, 32'h30, 32'h80000000, 16'd1);
    tick();
    cfg2_addr = 32'd0;
    repeat (3) tick();
    chk("w40_oor_data", m2_tdata[39:0], 0);
    chk("w40_oor_vld", m2_tvalid[0], 0);
    chk("w40_sext_data", m2_tdata[79:40], 40'hFF80000001);
    chk("w40_sext_vld", m2_tvalid[1], 1);
    chk("w40_test_data", m2_tdata[119:80], 40'hFF80000000);
    chk("w40_test_vld", m2_tvalid[2], 1);
    chk("w40_pos_data", m2_tdata[159:120], 40'h007FFFFFFF);
    chk("w40_pos_vld", m2_tvalid[3], 1);
    chk("w40_count", cnt2, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
